// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if
//   Bundles the signals between the three byte sources / mode FSM and the
//   tx_arbiter, plus the arbiter's outputs toward the serial transmitter.
//   master : en, start1..3, data1..3, clr_ovr out; arbiter outputs in
//   slave  : the arbiter itself (inverse directions)
interface tx_arbiter_if;
  logic [2:0] en;
  logic       start1;
  logic       start2;
  logic       start3;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] data3;
  logic       clr_ovr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [1:0] grant;
  logic [2:0] pending;
  logic [2:0] overrun;

  modport master (
    output en, start1, start2, start3, data1, data2, data3, clr_ovr,
    input  tx_data, tx_start, busy, grant, pending, overrun
  );

  modport slave (
    input  en, start1, start2, start3, data1, data2, data3, clr_ovr,
    output tx_data, tx_start, busy, grant, pending, overrun
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter
//   Round-robin arbiter sharing one serial transmitter among three byte
//   sources. Each source has a one-byte holding register; one frame is
//   launched at a time and timed locally (the transmitter has no busy output).
//   Ports:
//     sysclk  : clock, rising edge
//     reset   : asynchronous, active-high
//     bus     : tx_arbiter_if.slave (enables, start strobes, data bytes,
//               clr_ovr in; tx_data, tx_start, busy, grant, pending,
//               overrun out)
module tx_arbiter #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FRAME_BITS   = 10
) (
  input  logic        sysclk,
  input  logic        reset,
  tx_arbiter_if.slave bus
);
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_q, grant_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       overrun_q, overrun_d;
  logic [7:0]       hold_q [3];
  logic [7:0]       hold_d [3];

  logic [2:0]       start_s;
  logic [7:0]       data_s [3];
  logic             launch_s;
  logic [1:0]       winner_s;
  logic [2:0]       take_s;

  // Returns {found, index}: first requester after 'last' in the order
  // last+1, last+2, last+3 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0][1:0] order;
    logic            found;
    logic [1:0]      idx;
    case (last)
      2'd0:    order = {2'd0, 2'd2, 2'd1};
      2'd1:    order = {2'd1, 2'd0, 2'd2};
      default: order = {2'd2, 2'd1, 2'd0};
    endcase
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx   = (!found && req[order[k]]) ? order[k] : idx;
      found = found | req[order[k]];
    end
    return {found, idx};
  endfunction

  assign start_s   = {bus.start3, bus.start2, bus.start1};
  assign data_s[0] = bus.data1;
  assign data_s[1] = bus.data2;
  assign data_s[2] = bus.data3;

  // A launch is decided only from IDLE; disabled sources never win.
  assign {launch_s, winner_s} = (state_q == IDLE) ? rr_pick(pending_q & bus.en, grant_q) : 3'b000;
  assign take_s = launch_s ? (3'b001 << winner_s) : 3'b000;

  // Frame sequencing: next state, frame counter and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (launch_s) begin
          state_d    = LAUNCH;
          tx_data_d  = hold_q[winner_s];
          grant_d    = winner_s;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      LAUNCH: begin
        state_d = HOLD;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Holding registers, pending flags and sticky overrun flags.
  // A strobe on the same edge its source is granted refills the register
  // (the grant has consumed the old byte), so no overrun is raised.
  always_comb begin
    pending_d = pending_q;
    overrun_d = bus.clr_ovr ? 3'b000 : overrun_q;
    for (int i = 0; i < 3; i++) begin
      hold_d[i] = hold_q[i];
      if (!bus.en[i]) begin
        pending_d[i] = 1'b0;
      end else if (start_s[i]) begin
        if (!pending_q[i] || take_s[i]) begin
          hold_d[i]    = data_s[i];
          pending_d[i] = 1'b1;
        end else begin
          overrun_d[i] = 1'b1;
        end
      end else if (take_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 2'd2;
      pending_q  <= 3'b000;
      overrun_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.grant    = grant_q;
  assign bus.pending  = pending_q;
  assign bus.overrun  = overrun_q;
endmodule
